// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the dual-issue scheduler: state encodings,
// register-field width, default queue depth and the jal link register.
package issue_scheduler_pkg;

  localparam int unsigned AWIDTH = 5;
  localparam int unsigned ISSUE_DEPTH = 3;

  localparam logic [AWIDTH-1:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    ISSUE_RUN   = 2'd0,
    ISSUE_SPLIT = 2'd1,
    ISSUE_FLUSH = 2'd2
  } issue_state_t;

  // Effective destination register of a head: jal links to $31,
  // otherwise reg_dst chooses rd over rt.
  function automatic logic [AWIDTH-1:0] dest_sel(
    input logic              jal,
    input logic              reg_dst,
    input logic [AWIDTH-1:0] rd,
    input logic [AWIDTH-1:0] rt
  );
    if (jal) begin
      return LINK_REG;
    end
    return reg_dst ? rd : rt;
  endfunction

endpackage

// File: rtl/issue_scheduler_pair_hazard.sv
// pair_hazard: combinational check of whether the two queue heads may
// issue together in one cycle.
module pair_hazard
  import issue_scheduler_pkg::*;
(
  input  logic              a_reg_write,
  input  logic              a_reg_dst,
  input  logic              a_jal,
  input  logic              a_jr,
  input  logic              a_mem,
  input  logic              a_force_pipe1,
  input  logic [AWIDTH-1:0] a_addr_rd,
  input  logic [AWIDTH-1:0] a_addr_rt,
  input  logic              b_reg_write,
  input  logic              b_reg_dst,
  input  logic              b_jal,
  input  logic              b_mem,
  input  logic [AWIDTH-1:0] b_addr_rd,
  input  logic [AWIDTH-1:0] b_addr_rs,
  input  logic [AWIDTH-1:0] b_addr_rt,
  output logic              conflict
);

  logic [AWIDTH-1:0] dst_a;
  logic [AWIDTH-1:0] dst_b;
  logic              a_writes;
  logic              b_writes;
  logic              raw;
  logic              waw;

  // Flag RAW/WAW register dependences and structural pairing limits.
  always_comb begin
    dst_a    = dest_sel(a_jal, a_reg_dst, a_addr_rd, a_addr_rt);
    dst_b    = dest_sel(b_jal, b_reg_dst, b_addr_rd, b_addr_rt);
    a_writes = a_reg_write && (dst_a != '0);
    b_writes = b_reg_write && (dst_b != '0);
    raw      = a_writes && ((dst_a == b_addr_rs) || (dst_a == b_addr_rt));
    waw      = a_writes && b_writes && (dst_a == dst_b);
    conflict = raw || waw || (a_mem && b_mem) || a_jal || a_jr || a_force_pipe1;
  end

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: sequences the lockstep A/B instruction queues onto the
// two issue pipes (dual, A-then-B split, or drain on flush).
// State and occupancy update on the falling edge of is_clk.
// Optional macro ISSUE_PERF_EN adds dual-issue and stall counters.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = ISSUE_DEPTH
) (
  input  logic              is_clk,
  input  logic              is_rst,
  input  logic              is_i_fetch_valid,
  output logic              is_o_fetch_ready,
  output logic              is_o_qa_we,
  output logic              is_o_qb_we,
  output logic              is_o_qa_re,
  output logic              is_o_qb_re,
  input  logic              is_i_a_ce,
  input  logic              is_i_b_ce,
  input  logic              is_i_a_reg_write,
  input  logic              is_i_b_reg_write,
  input  logic              is_i_a_reg_dst,
  input  logic              is_i_b_reg_dst,
  input  logic              is_i_a_jal,
  input  logic              is_i_a_jr,
  input  logic              is_i_b_jal,
  input  logic              is_i_a_mem,
  input  logic              is_i_b_mem,
  input  logic              is_i_a_force_pipe1,
  input  logic [AWIDTH-1:0] is_i_a_addr_rd,
  input  logic [AWIDTH-1:0] is_i_a_addr_rt,
  input  logic [AWIDTH-1:0] is_i_b_addr_rd,
  input  logic [AWIDTH-1:0] is_i_b_addr_rs,
  input  logic [AWIDTH-1:0] is_i_b_addr_rt,
  input  logic              is_i_stall,
  input  logic              is_i_flush,
  output logic              is_o_issue0,
  output logic              is_o_issue1,
`ifdef ISSUE_PERF_EN
  output logic [31:0]       is_o_dual_cnt,
  output logic [31:0]       is_o_stall_cnt,
`endif
  output logic              is_o_swap
);

  localparam logic [DEPTH:0] CNT_FULL = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] CNT_ONE  = {{DEPTH{1'b0}}, 1'b1};

  issue_state_t   state, state_nxt;
  logic [DEPTH:0] cnt_a, cnt_b;
  logic           conflict;
  logic           a_avail, b_avail;
  logic           write_en;

  pair_hazard u_pair_hazard (
    .a_reg_write   (is_i_a_reg_write),
    .a_reg_dst     (is_i_a_reg_dst),
    .a_jal         (is_i_a_jal),
    .a_jr          (is_i_a_jr),
    .a_mem         (is_i_a_mem),
    .a_force_pipe1 (is_i_a_force_pipe1),
    .a_addr_rd     (is_i_a_addr_rd),
    .a_addr_rt     (is_i_a_addr_rt),
    .b_reg_write   (is_i_b_reg_write),
    .b_reg_dst     (is_i_b_reg_dst),
    .b_jal         (is_i_b_jal),
    .b_mem         (is_i_b_mem),
    .b_addr_rd     (is_i_b_addr_rd),
    .b_addr_rs     (is_i_b_addr_rs),
    .b_addr_rt     (is_i_b_addr_rt),
    .conflict      (conflict)
  );

  // Fetch handshake; a flush drops the pair presented in the same cycle.
  always_comb begin
    a_avail          = (cnt_a != '0);
    b_avail          = (cnt_b != '0);
    is_o_fetch_ready = (cnt_a < CNT_FULL) && (cnt_b < CNT_FULL) && (state != ISSUE_FLUSH);
    write_en         = is_i_fetch_valid && is_o_fetch_ready && !is_i_flush;
    is_o_qa_we       = write_en;
    is_o_qb_we       = write_en;
  end

  // Issue decision and next state from the heads and current state.
  always_comb begin
    state_nxt   = state;
    is_o_issue0 = 1'b0;
    is_o_issue1 = 1'b0;
    is_o_swap   = 1'b0;
    is_o_qa_re  = 1'b0;
    is_o_qb_re  = 1'b0;
    if (is_i_flush) begin
      state_nxt = ISSUE_FLUSH;
    end else begin
      unique case (state)
        ISSUE_RUN: begin
          if (!is_i_stall && a_avail && b_avail) begin
            is_o_qa_re = 1'b1;
            if (!conflict) begin
              is_o_issue0 = is_i_a_ce;
              is_o_issue1 = is_i_b_ce;
              is_o_qb_re  = 1'b1;
            end else begin
              // A goes alone; force_pipe1 steers it onto pipe 1 via swap.
              if (is_i_a_force_pipe1) begin
                is_o_issue1 = is_i_a_ce;
                is_o_swap   = is_i_a_ce;
              end else begin
                is_o_issue0 = is_i_a_ce;
              end
              state_nxt = ISSUE_SPLIT;
            end
          end
        end
        ISSUE_SPLIT: begin
          if (!is_i_stall) begin
            is_o_issue1 = is_i_b_ce;
            is_o_qb_re  = 1'b1;
            state_nxt   = ISSUE_RUN;
          end
        end
        ISSUE_FLUSH: begin
          is_o_qa_re = a_avail;
          is_o_qb_re = b_avail;
          if (!a_avail && !b_avail) begin
            state_nxt = ISSUE_RUN;
          end
        end
        default: state_nxt = ISSUE_RUN;
      endcase
    end
  end

  // State register and queue occupancy tracking.
  always_ff @(negedge is_clk or negedge is_rst) begin
    if (!is_rst) begin
      state <= ISSUE_RUN;
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      state <= state_nxt;
      unique case ({is_o_qa_we, is_o_qa_re})
        2'b10:   cnt_a <= cnt_a + CNT_ONE;
        2'b01:   cnt_a <= cnt_a - CNT_ONE;
        default: cnt_a <= cnt_a;
      endcase
      unique case ({is_o_qb_we, is_o_qb_re})
        2'b10:   cnt_b <= cnt_b + CNT_ONE;
        2'b01:   cnt_b <= cnt_b - CNT_ONE;
        default: cnt_b <= cnt_b;
      endcase
    end
  end

`ifdef ISSUE_PERF_EN
  // Dual-issue and backend-stall performance counters (wrap at 2**32).
  always_ff @(negedge is_clk or negedge is_rst) begin
    if (!is_rst) begin
      is_o_dual_cnt  <= '0;
      is_o_stall_cnt <= '0;
    end else begin
      if (is_o_issue0 && is_o_issue1) begin
        is_o_dual_cnt <= is_o_dual_cnt + 32'd1;
      end
      if (is_i_stall && a_avail) begin
        is_o_stall_cnt <= is_o_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dual-issue scheduler that sequences the two per-slot instruction queues of the superscalar MIPS front end. Fetch writes instruction pairs (slot A, slot B) into queue A and queue B in lockstep. Each cycle the block inspects both queue heads and decides whether to issue dual, issue A only, or issue B only. It drives the queue read enables and the two pipe issue strobes. It also drains both queues on a pipeline flush.

## Interface
- DEPTH, 3: log2 of queue entries, matching the queue instances; occupancy counters are DEPTH+1 bits wide.
- is_clk  in  1  clock; all state updates on its falling edge, aligned with the queues.
- is_rst  in  1  asynchronous, active-low reset.
- is_i_fetch_valid  in  1  fetch presents a pair this cycle.
- is_o_fetch_ready  out  1  space for a pair: both counts < 2**DEPTH and state != FLUSH.
- is_o_qa_we, is_o_qb_we  out  1  queue write enables; both equal fetch_valid & fetch_ready.
- is_o_qa_re, is_o_qb_re  out  1  queue read enables.
- is_i_a_ce, is_i_b_ce  in  1  head entry valid; 0 marks a bubble.
- is_i_a_reg_write, is_i_b_reg_write  in  1  head writes the register file.
- is_i_a_reg_dst, is_i_b_reg_dst  in  1  destination select: 1 = rd, 0 = rt.
- is_i_a_jal, is_i_a_jr  in  1  slot A is jal/jr.
- is_i_b_jal  in  1  slot B is jal.
- is_i_a_mem, is_i_b_mem  in  1  memtoreg | memwrite of the head.
- is_i_a_force_pipe1  in  1  slot A must execute on pipe 1.
- is_i_a_addr_rd, is_i_a_addr_rt  in  AWIDTH  slot A head register fields.
- is_i_b_addr_rd, is_i_b_addr_rs, is_i_b_addr_rt  in  AWIDTH  slot B head register fields.
- is_i_stall  in  1  backend cannot accept issue.
- is_i_flush  in  1  redirect; discard all queued instructions.
- is_o_issue0  out  1  pipe 0 takes queue A head.
- is_o_issue1  out  1  pipe 1 takes a head.
- is_o_swap  out  1  pipe 1 takes queue A head instead of B.
- is_o_dual_cnt, is_o_stall_cnt  out  32  performance counters; present only with ISSUE_PERF_EN.

## Operation
- Counters cnt_a and cnt_b track queue occupancy. A write increments the counter and a read decrements it. Simultaneous write and read leaves the counter unchanged.
- States:
  - RUN: default state.
  - SPLIT: A has issued and B is pending.
  - FLUSH: draining.
- Destination of A:
  - 31 if jal.
  - Otherwise rd if reg_dst, else rt.
  - Counts as a write only when reg_write is set and the destination is nonzero.
- Pair conflict in RUN, when any of the following holds:
  - A writes a destination equal to B.rs or B.rt (RAW).
  - A and B both write the same nonzero destination (WAW).
  - A.mem & B.mem.
  - A.jal | A.jr.
  - A.force_pipe1.
- RUN with both counts > 0, no stall, no conflict:
  - issue0 = A.ce, issue1 = B.ce.
  - qa_re = qb_re = 1.
  - Bubbles are consumed without an issue strobe.
- RUN with a conflict:
  - A issues alone: issue0, or issue1 with swap if force_pipe1.
  - qa_re = 1.
  - Next state is SPLIT.
- SPLIT, no stall:
  - issue1 = B.ce, qb_re = 1.
  - Next state is RUN.
- Stall: no issue strobe and no read enable; state is held. Writes continue.
- Flush, in any state and overriding stall:
  - Enter FLUSH; the write of that cycle is dropped.
  - In FLUSH, qa_re = (cnt_a > 0) and qb_re = (cnt_b > 0), with no issue.
  - Return to RUN when both counts are 0. With both counts already 0 this takes one cycle.
- Empty (cnt_a == 0 in RUN): no issue, no read.

## Timing
- Issue decision is combinational from the heads and the state. Read enable is asserted in the same cycle as the issue strobe. Pointers, counters and state update at the next falling edge.
- Issue latency is 0 cycles from head valid. A conflicting pair takes 2 issue cycles.
- Reset values:
  - State is RUN and both counts are 0.
  - All issue and read outputs are 0, and swap is 0.
  - fetch_ready is 1; we follows fetch_valid.
  - Perf counters are 0.
- Reset mid-FLUSH or mid-SPLIT returns to RUN with counts 0. The queues share the same reset.
- Full: at cnt == 2**DEPTH, fetch_ready is 0. A read in the same cycle does not re-enable fetch_ready until the next cycle.

## Configuration
- ISSUE_PERF_EN defined: is_o_dual_cnt and is_o_stall_cnt ports are present.
  - dual_cnt increments on every cycle with issue0 & issue1.
  - stall_cnt increments on every cycle with stall & cnt_a > 0.
  - Both counters wrap at 2**32.
- ISSUE_PERF_EN undefined: both ports and their counters are absent. Scheduling behaviour is identical.

## Structure
- Shared header holds the state encodings ISSUE_RUN=0, ISSUE_SPLIT=1, ISSUE_FLUSH=2, the AWIDTH and DEPTH defines, and the constant 31 used as the jal link register.
- One sub-module, pair_hazard: combinational conflict detection from the two heads. It outputs conflict only.

## Test plan
- Pair A=add $3←$1,$2 and B=sub $4←$5,$6 written, no stall -> one cycle with issue0=issue1=1, both read enables 1, dual_cnt=1.
- A writes $3 and B reads rs=$3 -> cycle 1: issue0 only, qa_re=1. Cycle 2 in SPLIT: issue1 only, qb_re=1.
- A and B both loads -> split issue. A with force_pipe1 -> issue1=1 and swap=1 alone.
- Write 8 pairs with stall held and DEPTH=3 -> fetch_ready=0 after the 8th pair. Release stall -> fetch_ready returns to 1 the cycle after the first read.
- 5 pairs queued, assert flush for one cycle together with fetch_valid -> no write, 5 drain cycles with no issue, then RUN, counts 0.
- Reset asserted mid-SPLIT -> all outputs at reset values immediately, state RUN after release.
